// File: rtl/unary_ser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : unary_ser                                                     |
// | Purpose  : Serializes one thermometer-coded word into per-unit tokens.   |
// |            Each token is {last, index}; valid/ready on both sides.       |
// | Option   : UNARY_SER_CHECK_EN adds a sticky err output flagging words    |
// |            that are not valid thermometer codes.                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module unary_ser #(
   parameter int W_UNARY = 8,
   parameter int W_IDX   = $clog2(W_UNARY)
) (
   input  logic               clk,
   input  logic               rst,
   output logic               din_ready,
   input  logic               din_valid,
   input  logic [W_UNARY-1:0] din_data,
   input  logic               dout_ready,
   output logic               dout_valid,
   output logic [W_IDX:0]     dout_data
`ifdef UNARY_SER_CHECK_EN
   ,
   output logic               err
`endif
);

   localparam logic [0:0]     c_IDLE    = 1'b0;
   localparam logic [0:0]     c_EMIT    = 1'b1;
   localparam logic [W_IDX:0] c_LEN_ONE = (W_IDX+1)'(1);
   localparam logic [W_IDX-1:0] c_IDX_ONE = W_IDX'(1);

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [W_IDX-1:0] r_idx;
   logic [W_IDX:0]   r_len;
   logic [W_IDX:0]   w_len;
   logic             w_run;
   logic             w_last;
   logic             w_accept;
   logic             w_load;
   logic             w_advance;

   // Run length of consecutive ones from bit 0; anything past the first zero is ignored
   always_comb begin
      w_len = '0;
      w_run = 1'b1;
      for (int i = 0; i < W_UNARY; i++) begin
         w_run = w_run & din_data[i];
         if (w_run) begin
            w_len = (W_IDX+1)'(i + 1);
         end
      end
   end

   assign w_last   = ({1'b0, r_idx} == (r_len - c_LEN_ONE));
   assign w_accept = din_valid && din_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a new word may be loaded on the same edge as the final token
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_advance   = 1'b0;
      case (r_state)
         c_IDLE: begin
            if (w_accept) begin
               w_load      = 1'b1;
               w_state_nxt = (w_len != '0) ? c_EMIT : c_IDLE;
            end
         end
         c_EMIT: begin
            if (dout_ready) begin
               if (!w_last) begin
                  w_advance = 1'b1;
               end else if (w_accept) begin
                  w_load      = 1'b1;
                  w_state_nxt = (w_len != '0) ? c_EMIT : c_IDLE;
               end else begin
                  w_state_nxt = c_IDLE;
               end
            end
         end
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Outputs; din_ready in EMIT passes dout_ready through so words chain without a bubble
   always_comb begin
      din_ready  = 1'b0;
      dout_valid = 1'b0;
      dout_data  = '0;
      if (!rst) begin
         case (r_state)
            c_IDLE: din_ready = 1'b1;
            c_EMIT: begin
               dout_valid = 1'b1;
               dout_data  = {w_last, r_idx};
               din_ready  = w_last && dout_ready;
            end
            default: din_ready = 1'b0;
         endcase
      end
   end

   // Token index and word length registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
         r_len <= '0;
      end else if (w_load) begin
         r_idx <= '0;
         r_len <= w_len;
      end else if (w_advance) begin
         r_idx <= r_idx + c_IDX_ONE;
      end
   end

`ifdef UNARY_SER_CHECK_EN
   logic w_bad;

   // A one at or above the run length means the word is not a thermometer code
   always_comb begin
      w_bad = 1'b0;
      for (int i = 0; i < W_UNARY; i++) begin
         if (((W_IDX+1)'(i) >= w_len) && din_data[i]) begin
            w_bad = 1'b1;
         end
      end
   end

   // Sticky malformed-input flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (w_accept && w_bad) begin
         err <= 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_unary_ser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_unary_ser                                                  |
// | Purpose  : Self-checking bench for unary_ser; queue-based token model    |
// |            plus directed literal checks and randomized traffic.          |
// | Option   : UNARY_SER_CHECK_EN enables err checking.                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_unary_ser;

   localparam int W  = 8;
   localparam int WI = $clog2(W);

   logic          clk;
   logic          rst;
   logic          din_ready;
   logic          din_valid;
   logic [W-1:0]  din_data;
   logic          dout_ready;
   logic          dout_valid;
   logic [WI:0]   dout_data;
`ifdef UNARY_SER_CHECK_EN
   logic          err;
   logic          m_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Expected tokens still owed for the word in flight, front = currently shown
   logic [WI:0] q[$];

   unary_ser #(.W_UNARY(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .din_ready  (din_ready),
      .din_valid  (din_valid),
      .din_data   (din_data),
      .dout_ready (dout_ready),
      .dout_valid (dout_valid),
      .dout_data  (dout_data)
`ifdef UNARY_SER_CHECK_EN
      ,
      .err        (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int run_len(input logic [W-1:0] d);
      int n = 0;
      while (n < W && d[n]) n++;
      return n;
   endfunction

   function automatic logic is_thermo(input logic [W-1:0] d);
      int n = run_len(d);
      for (int i = n; i < W; i++) if (d[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic m_ready();
      return (q.size() == 0) || (q.size() == 1 && dout_ready);
   endfunction

   // Model update on each edge using the inputs held across it
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
`ifdef UNARY_SER_CHECK_EN
         m_err = 1'b0;
`endif
      end else begin
         logic rdy;
         int   n;
         rdy = m_ready();
         if (q.size() > 0 && dout_ready) void'(q.pop_front());
         if (din_valid && rdy) begin
            n = run_len(din_data);
            for (int k = 0; k < n; k++) q.push_back({(k == n - 1), WI'(k)});
`ifdef UNARY_SER_CHECK_EN
            if (!is_thermo(din_data)) m_err = 1'b1;
`endif
         end
      end
   end

   // Compare DUT against the model mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_valid", 32'(dout_valid), 0);
         chk("rst_data",  32'(dout_data), 0);
         chk("rst_ready", 32'(din_ready), 0);
      end else begin
         chk("mdl_valid", 32'(dout_valid), 32'(q.size() > 0));
         chk("mdl_data",  32'(dout_data), (q.size() > 0) ? 32'(q[0]) : 0);
         chk("mdl_ready", 32'(din_ready), 32'(m_ready()));
      end
`ifdef UNARY_SER_CHECK_EN
      chk("mdl_err", 32'(err), rst ? 0 : 32'(m_err));
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   initial begin
      int r;
      int l;
      rst = 1'b1; din_valid = 1'b0; din_data = '0; dout_ready = 1'b0;
      look();
      chk("reset_valid", 32'(dout_valid), 0);
      chk("reset_ready", 32'(din_ready), 0);
      #2 rst = 1'b0;

      // 1: three-unit word
      step(); din_valid = 1'b1; din_data = 8'h07; dout_ready = 1'b1;
      look(); chk("t1_idle_ready", 32'(din_ready), 1);
      step(); din_valid = 1'b0;
      look(); chk("t1_v0", 32'(dout_valid), 1); chk("t1_d0", 32'(dout_data), 32'h0);
      step(); look(); chk("t1_d1", 32'(dout_data), 32'h1);
      step(); look(); chk("t1_d2", 32'(dout_data), 32'hA); chk("t1_rdy", 32'(din_ready), 1);
      step(); look(); chk("t1_end", 32'(dout_valid), 0);

      // 2: empty word then single unit
      step(); din_valid = 1'b1; din_data = 8'h00;
      step(); din_data = 8'h01;
      look(); chk("t2_novalid", 32'(dout_valid), 0); chk("t2_rdy", 32'(din_ready), 1);
      step(); din_valid = 1'b0;
      look(); chk("t2_tok", 32'(dout_data), 32'h8);
      step(); look(); chk("t2_end", 32'(dout_valid), 0);

      // 3: back-to-back words
      step(); din_valid = 1'b1; din_data = 8'h01;
      step(); din_data = 8'h03;
      look(); chk("t3_a", 32'(dout_data), 32'h8); chk("t3_rdy", 32'(din_ready), 1);
      step(); din_valid = 1'b0;
      look(); chk("t3_b", 32'(dout_data), 32'h0); chk("t3_bv", 32'(dout_valid), 1);
      step(); look(); chk("t3_c", 32'(dout_data), 32'h9);
      step(); look(); chk("t3_end", 32'(dout_valid), 0);

      // 4: full word with backpressure at index 4
      step(); din_valid = 1'b1; din_data = 8'hFF;
      step(); din_valid = 1'b0;
      repeat (4) step();
      dout_ready = 1'b0;
      repeat (3) begin
         look(); chk("t4_hold", 32'(dout_data), 32'h4);
         step();
      end
      dout_ready = 1'b1;
      look(); chk("t4_resume", 32'(dout_data), 32'h4);
      repeat (3) step();
      look(); chk("t4_last", 32'(dout_data), 32'hF);
      step(); look(); chk("t4_end", 32'(dout_valid), 0);

      // 5: asynchronous reset in the middle of a word
      step(); din_valid = 1'b1; din_data = 8'h3F;
      step(); din_valid = 1'b0;
      step(); step();
      #2 rst = 1'b1;
      #1 chk("t5_async_valid", 32'(dout_valid), 0); chk("t5_async_rdy", 32'(din_ready), 0);
      #2 rst = 1'b0;
      step(); din_valid = 1'b1; din_data = 8'h03;
      step(); din_valid = 1'b0;
      look(); chk("t5_a", 32'(dout_data), 32'h0);
      step(); look(); chk("t5_b", 32'(dout_data), 32'h9);
      step(); look(); chk("t5_end", 32'(dout_valid), 0);

`ifdef UNARY_SER_CHECK_EN
      // 6: malformed word sets sticky err
      step(); din_valid = 1'b1; din_data = 8'h05;
      step(); din_valid = 1'b0;
      look(); chk("t6_tok", 32'(dout_data), 32'h8); chk("t6_err", 32'(err), 1);
      step(); din_valid = 1'b1; din_data = 8'h03;
      step(); din_valid = 1'b0;
      repeat (3) step();
      look(); chk("t6_sticky", 32'(err), 1);
      #2 rst = 1'b1;
      #1 chk("t6_clr", 32'(err), 0);
      #3 rst = 1'b0;
`endif

      // Randomized traffic
      repeat (3000) begin
         step();
         din_valid  = ($urandom % 2) == 0;
         dout_ready = ($urandom % 4) != 0;
         r = $urandom % 4;
         case (r)
            0: begin
               l = $urandom_range(0, W);
               din_data = W'((9'h1 << l) - 9'h1);
            end
            1: din_data = 8'hFF;
            2: din_data = W'($urandom);
            default: din_data = 8'h00;
         endcase
      end
      step(); din_valid = 1'b0; dout_ready = 1'b1;
      repeat (12) step();
      look();
      chk("drain_empty", 32'(dout_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
